// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants, derived totals and sync windows,
// and the sync-bundle type used by vga_sync_gen and the pixel generators that need screen bounds.
package vga_sync_gen_pkg;

   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_H_TOTAL      = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL      = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
   localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
   localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
   localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

   localparam int COORD_W = 10;
   localparam int RGB_W   = 12;

   // hsync/vsync are active-low, so the idle bundle drives them high
   typedef struct packed {
      logic video_on;
      logic hsync;
      logic vsync;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};

   function automatic logic in_window(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Pixel-rate divider: p_tick is a registered one-clk pulse, high in the clk after the
// divider count reaches CLK_DIV-1.
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             p_tick_q;

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (div_q == DIV_LAST) div_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q    <= '0;
         p_tick_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         p_tick_q <= (div_q == DIV_LAST);
      end
   end

   assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster source: pixel counters, sync/blanking and colour gating.
// Define VGA_RGB_REG_EN to register rgb_out and the sync pins one extra pixel.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [RGB_W-1:0]   rgb_in,
   output logic               p_tick,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               video_on,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start,
   output logic [RGB_W-1:0]   rgb_out
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic               tick;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   sync_t              sync_q, sync_d;
   logic               frame_q;

   pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .p_tick (tick)
   );

   always_comb begin
      x_d = x_q + COORD_W'(1);
      y_d = y_q;
      if (x_q == H_LAST) begin
         x_d = '0;
         y_d = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
      end
   end

   // Decoded from the next counts so the registered flags line up with pixel_x/pixel_y
   always_comb begin
      sync_d          = SYNC_IDLE;
      sync_d.video_on = (x_d < H_VIS) && (y_d < V_VIS);
      sync_d.hsync    = ~in_window(x_d, HS_START, HS_END);
      sync_d.vsync    = ~in_window(y_d, VS_START, VS_END);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         sync_q  <= SYNC_IDLE;
         frame_q <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         if (tick) begin
            x_q     <= x_d;
            y_q     <= y_d;
            sync_q  <= sync_d;
            frame_q <= (x_d == '0) && (y_d == '0);
         end
      end
   end

   assign p_tick      = tick;
   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign frame_start = frame_q;

`ifdef VGA_RGB_REG_EN
   sync_t            pin_q;
   logic [RGB_W-1:0] rgb_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pin_q <= SYNC_IDLE;
         rgb_q <= '0;
      end else if (tick) begin
         pin_q <= sync_q;
         rgb_q <= sync_q.video_on ? rgb_in : '0;
      end
   end

   assign video_on = pin_q.video_on;
   assign hsync    = pin_q.hsync;
   assign vsync    = pin_q.vsync;
   assign rgb_out  = rgb_q;
`else
   assign video_on = sync_q.video_on;
   assign hsync    = sync_q.hsync;
   assign vsync    = sync_q.vsync;
   assign rgb_out  = sync_q.video_on ? rgb_in : '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (15x11 pixels, 4 clks per pixel).
// Expected outputs come from a pixel-index model: position k = (clks since reset - 1) / CLK_DIV.
module tb_vga_sync_gen;

  localparam int CLK_DIV = 4;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 2, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;
  localparam int W = 37;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rgb_in = '0;
  logic        p_tick, video_on, hsync, vsync, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb_out;

  vga_sync_gen #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(p_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .rgb_out(rgb_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int          n = 0;
  bit          rst_prev = 1'b1;
  logic [11:0] rgb_prev = '0;
  logic [11:0] reg_rgb = '0;

  function automatic int pix_index(input int clks);
    return (clks > 0) ? (clks - 1) / CLK_DIV : 0;
  endfunction

  // {video_on, hsync, vsync} for raster position k; k=0 is the blanked reset pixel
  function automatic logic [2:0] raster_flags(input int k);
    int x, y;
    logic vid, hs, vs;
    if (k == 0) return 3'b011;
    x = k % HT;
    y = (k / HT) % VT;
    vid = (x < HD) && (y < VD);
    hs = !((x >= HD + HF) && (x < HD + HF + HS));
    vs = !((y >= VD + VF) && (y < VD + VF + VS));
    return {vid, hs, vs};
  endfunction

  // driver: one clk per call; records what the DUT must show after the edge just passed
  task automatic step(input bit rst_next, input logic [11:0] rgb_next);
    int          n_old, k;
    logic [2:0]  f;
    logic [11:0] erg;
    bit          tick_now, fs;
    @(negedge clk);
    n_old = n;
    if (rst_prev) begin
      n = 0;
      reg_rgb = '0;
    end else begin
      if (n_old > 0 && n_old % CLK_DIV == 0) begin
        f = raster_flags(pix_index(n_old));
        reg_rgb = f[2] ? rgb_prev : 12'h000;
      end
      n = n_old + 1;
    end
    k = pix_index(n);
    tick_now = (n > 0) && (n % CLK_DIV == 0);
    fs = (k > 0) && (k % (HT * VT) == 0) && ((n - 1) % CLK_DIV == 0);
    rgb_in = rgb_next;
`ifdef VGA_RGB_REG_EN
    f = raster_flags((k == 0) ? 0 : k - 1);
    erg = reg_rgb;
`else
    f = raster_flags(k);
    erg = f[2] ? rgb_next : 12'h000;
`endif
    exp_q.push_back({tick_now, 10'(k % HT), 10'((k / HT) % VT), f, fs, erg});
    reset = rst_next;
    rst_prev = rst_next;
    rgb_prev = rgb_next;
  endtask

  // monitor: compares the DUT outputs every clk against the oldest expectation
  initial begin
    logic [W-1:0] got, e;
    forever begin
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t: DUT output with no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        got = {p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start, rgb_out};
        if (got !== e) begin
          errors++;
          $display("FAIL raster t=%0t got tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b rgb=%h exp tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b rgb=%h",
                   $time, got[36], got[35:26], got[25:16], got[15], got[14], got[13], got[12], got[11:0],
                   e[36], e[35:26], e[25:16], e[15], e[14], e[13], e[12], e[11:0]);
        end
      end
    end
  end

  initial begin
    int mid;
    for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom));
    for (int i = 0; i < 2 * FRAME_CLKS + 50; i++) step(1'b0, 12'($urandom));
    for (int i = 0; i < 400; i++) step(1'b0, 12'hFFF);
    mid = $urandom_range(50, FRAME_CLKS - 50);
    for (int i = 0; i < mid; i++) step(1'b0, 12'($urandom));
    step(1'b1, 12'($urandom));
    for (int i = 0; i < FRAME_CLKS + 200; i++) step(1'b0, 12'($urandom_range(0, 4095)));
    for (int i = 0; i < 5; i++) step(1'b1, 12'hFFF);
    for (int i = 0; i < 300; i++) step(1'b0, 12'($urandom));
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
